proc_status_reg: RTL and testbench
==================================

PROC_STATUS_REG -- requirements
Module: proc_status_reg

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 alu_result  in  8  ALU result byte; source for N (bit 7) and Z (all-zero).
REQ-004 alu_cout  in  1  ALU carry-out.
REQ-005 alu_vout  in  1  ALU overflow-out.
REQ-006 upd_nz  in  1  load N,Z from alu_result.
REQ-007 upd_c  in  1  load C from alu_cout.
REQ-008 upd_v  in  1  load V from alu_vout.
REQ-009 bit_op  in  1  BIT instruction: N<=mem_in[7], V<=mem_in[6], Z<=(alu_result==0).
REQ-010 mem_in  in  8  operand byte for BIT and for P pull.
REQ-011 load_p  in  1  PLP/RTI: load all stored flags from mem_in.
REQ-012 flag_op  in  3  explicit flag op: 0 NOP, 1 CLC, 2 SEC, 3 CLI, 4 SEI, 5 CLD, 6 SED, 7 CLV.
REQ-013 int_entry  in  1  interrupt/BRK sequence: set I.
REQ-014 brk_push  in  1  B-bit value inserted into p_out for stack push.
REQ-015 p_out  out  8  {N,V,1,brk_push,D,I,Z,C}, pushed by PHP/BRK/IRQ.
REQ-016 c_flag  out  1  registered C; drives cin of the ALU carry mux.
REQ-017 z_flag, n_flag, v_flag  out  1 each  registered flags for branch evaluation.
REQ-018 d_flag  out  1  decimal mode to ALU.
REQ-019 i_flag  out  1  IRQ mask to interrupt logic.

Function
REQ-020 Stored state SHALL be six bits N,V,D,I,Z,C; bits 5 and 4 SHALL NOT be stored.
REQ-021 All flag outputs SHALL be direct register outputs; p_out bit 4 SHALL be the only combinational path (from brk_push); p_out bit 5 SHALL be constant 1.
REQ-022 Every update SHALL be visible on outputs exactly one clk edge after the qualifying inputs are sampled (latency 1).
REQ-023 Per-flag priority, highest first: rst, load_p, int_entry (I only), flag_op, bit_op (N,V,Z), upd_nz/upd_c/upd_v.
REQ-024 load_p SHALL load N=mem_in[7], V=[6], D=[3], I=[2], Z=[1], C=[0]; mem_in[5:4] ignored; all other update inputs ignored that cycle.
REQ-025 flag_op SHALL modify only its target flag; other flags still take lower-priority updates in the same cycle.
REQ-026 bit_op and upd_nz asserted together: bit_op wins for N and Z.
REQ-027 int_entry with flag_op=CLI same cycle: I SHALL become 1.
REQ-028 Z SHALL be 1 iff alu_result==8'h00; N SHALL equal alu_result[7].
REQ-029 No enable asserted: all flags SHALL hold.
REQ-030 Flag values SHALL be independent of d_flag; BCD flag correction is the ALU's job.

Reset
REQ-031 rst asserted SHALL immediately force N=V=D=Z=C=0, I=1, independent of clk.
REQ-032 While rst high, outputs SHALL hold reset values: p_out=8'h24 with brk_push=0, 8'h34 with brk_push=1.
REQ-033 First update SHALL occur on the first rising edge after rst deasserts; reset mid-update SHALL discard the update.

Structure
REQ-034 flag_op encodings and P bit positions (N=7, V=6, B=4, D=3, I=2, Z=1, C=0) SHALL live in the shared CPU constants package/header used by the control decoder.
REQ-035 One combinational sub-module nz_gen (8-bit in -> n,z) SHALL be used, reusable by the ALU for status previews.

Verification
REQ-036 Reset: pulse rst mid-cycle -> p_out=8'h24, c_flag=0, i_flag=1 without a clock edge.
REQ-037 ALU update: alu_result=8'h00, alu_cout=1, alu_vout=1, upd_nz=upd_c=upd_v=1 -> next edge Z=1, N=0, C=1, V=1; p_out=8'h63.
REQ-038 Priority: load_p=1, mem_in=8'hFF, flag_op=CLC, upd_c=1, alu_cout=0 -> next edge N,V,D,I,Z,C all 1; p_out=8'hEF (brk_push=0).
REQ-039 BIT: mem_in=8'hC0, alu_result=8'h00, bit_op=1, upd_nz=1 -> N=1, V=1, Z=1; C unchanged.
REQ-040 Concurrent ops: flag_op=SEC with upd_nz=1, alu_result=8'h80 -> C=1, N=1, Z=0; then int_entry=1 with flag_op=CLI -> I=1.
REQ-041 Carry path: SEC then CLC on consecutive cycles -> c_flag 1 then 0, each one edge after its op; hold 5 idle cycles -> no flag changes.

Source files
------------

// File: rtl/proc_status_reg_pkg.sv
// Shared CPU status constants: P bit positions, flag_op encodings and the
// stored-flag payload used by the status register and the control decoder.
package proc_status_reg_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned FLAG_OP_W = 3;

  localparam int unsigned P_N = 7;
  localparam int unsigned P_V = 6;
  localparam int unsigned P_U = 5;
  localparam int unsigned P_B = 4;
  localparam int unsigned P_D = 3;
  localparam int unsigned P_I = 2;
  localparam int unsigned P_Z = 1;
  localparam int unsigned P_C = 0;

  typedef enum logic [FLAG_OP_W-1:0] {
    FOP_NOP = 3'd0,
    FOP_CLC = 3'd1,
    FOP_SEC = 3'd2,
    FOP_CLI = 3'd3,
    FOP_SEI = 3'd4,
    FOP_CLD = 3'd5,
    FOP_SED = 3'd6,
    FOP_CLV = 3'd7
  } flag_op_e;

  typedef struct packed {
    logic n;
    logic v;
    logic d;
    logic i;
    logic z;
    logic c;
  } flags_t;

  // Power-on state: only the IRQ mask is set.
  localparam flags_t FLAGS_RST = flags_t'(6'b000100);

  function automatic logic [DATA_W-1:0] pack_p(input flags_t f, input logic b);
    logic [DATA_W-1:0] p;
    p      = '0;
    p[P_N] = f.n;
    p[P_V] = f.v;
    p[P_U] = 1'b1;
    p[P_B] = b;
    p[P_D] = f.d;
    p[P_I] = f.i;
    p[P_Z] = f.z;
    p[P_C] = f.c;
    return p;
  endfunction

endpackage

// File: rtl/proc_status_reg_nz_gen.sv
// Combinational N/Z generator for a result byte; shared with the ALU for
// status previews.
module nz_gen
  import proc_status_reg_pkg::*;
(
  input  logic [DATA_W-1:0] value,
  output logic              n,
  output logic              z
);

  assign n = value[DATA_W-1];
  assign z = (value == DATA_W'(0));

endmodule

// File: rtl/proc_status_reg.sv
// Processor status register: six stored flags N,V,D,I,Z,C with prioritized
// per-flag updates and the assembled P byte for stack pushes.
module proc_status_reg
  import proc_status_reg_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_W-1:0]    alu_result,
  input  logic                 alu_cout,
  input  logic                 alu_vout,
  input  logic                 upd_nz,
  input  logic                 upd_c,
  input  logic                 upd_v,
  input  logic                 bit_op,
  input  logic [DATA_W-1:0]    mem_in,
  input  logic                 load_p,
  input  logic [FLAG_OP_W-1:0] flag_op,
  input  logic                 int_entry,
  input  logic                 brk_push,
  output logic [DATA_W-1:0]    p_out,
  output logic                 c_flag,
  output logic                 z_flag,
  output logic                 n_flag,
  output logic                 v_flag,
  output logic                 d_flag,
  output logic                 i_flag
);

  flags_t   flags_q;
  flags_t   flags_d;
  flag_op_e op;
  logic     res_n;
  logic     res_z;
  logic     unused_mem;

  assign op = flag_op_e'(flag_op);
  // A pulled P carries B and the constant bit; neither is stored.
  assign unused_mem = ^mem_in[P_U:P_B];

  nz_gen u_nz_gen (
    .value (alu_result),
    .n     (res_n),
    .z     (res_z)
  );

  // Next state: later assignments override earlier ones, so lower-priority
  // sources come first.
  always_comb begin
    flags_d = flags_q;
    if (load_p) begin
      flags_d.n = mem_in[P_N];
      flags_d.v = mem_in[P_V];
      flags_d.d = mem_in[P_D];
      flags_d.i = mem_in[P_I];
      flags_d.z = mem_in[P_Z];
      flags_d.c = mem_in[P_C];
    end else begin
      if (upd_nz) begin
        flags_d.n = res_n;
        flags_d.z = res_z;
      end
      if (upd_c) flags_d.c = alu_cout;
      if (upd_v) flags_d.v = alu_vout;
      if (bit_op) begin
        flags_d.n = mem_in[P_N];
        flags_d.v = mem_in[P_V];
        flags_d.z = res_z;
      end
      case (op)
        FOP_CLC: flags_d.c = 1'b0;
        FOP_SEC: flags_d.c = 1'b1;
        FOP_CLI: flags_d.i = 1'b0;
        FOP_SEI: flags_d.i = 1'b1;
        FOP_CLD: flags_d.d = 1'b0;
        FOP_SED: flags_d.d = 1'b1;
        FOP_CLV: flags_d.v = 1'b0;
        default: ;
      endcase
      if (int_entry) flags_d.i = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) flags_q <= FLAGS_RST;
    else     flags_q <= flags_d;
  end

  assign n_flag = flags_q.n;
  assign v_flag = flags_q.v;
  assign d_flag = flags_q.d;
  assign i_flag = flags_q.i;
  assign z_flag = flags_q.z;
  assign c_flag = flags_q.c;
  // brk_push is the only combinational path to an output.
  assign p_out  = pack_p(flags_q, brk_push);

endmodule

// File: tb/tb_proc_status_reg.sv
// Scoreboard bench for proc_status_reg: directed vectors push hand-computed
// P bytes; a monitor pops and compares one edge later.
module tb_proc_status_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] alu_result;
  logic       alu_cout, alu_vout;
  logic       upd_nz, upd_c, upd_v, bit_op, load_p, int_entry, brk_push;
  logic [7:0] mem_in;
  logic [2:0] flag_op;
  logic [7:0] p_out;
  logic       c_flag, z_flag, n_flag, v_flag, d_flag, i_flag;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] exp_q[$];

  localparam logic [2:0] NOP = 3'd0, CLC = 3'd1, SEC = 3'd2, CLI = 3'd3,
                         SEI = 3'd4, CLD = 3'd5, SED = 3'd6, CLV = 3'd7;

  proc_status_reg dut (
    .clk(clk), .rst(rst), .alu_result(alu_result), .alu_cout(alu_cout),
    .alu_vout(alu_vout), .upd_nz(upd_nz), .upd_c(upd_c), .upd_v(upd_v),
    .bit_op(bit_op), .mem_in(mem_in), .load_p(load_p), .flag_op(flag_op),
    .int_entry(int_entry), .brk_push(brk_push), .p_out(p_out),
    .c_flag(c_flag), .z_flag(z_flag), .n_flag(n_flag), .v_flag(v_flag),
    .d_flag(d_flag), .i_flag(i_flag)
  );

  always #5 clk = ~clk;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %02h required %02h", name, act, req);
    end
  endtask

  function automatic logic [7:0] flags_byte();
    return {n_flag, v_flag, 1'b1, brk_push, d_flag, i_flag, z_flag, c_flag};
  endfunction

  // Monitor: state is presented every cycle, compared when an expectation exists.
  initial begin
    logic [7:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check8("p_out", p_out, e);
        check8("flags", flags_byte(), e);
      end
    end
  end

  task automatic idle_inputs();
    alu_result = 8'h55; alu_cout = 1'b0; alu_vout = 1'b0;
    upd_nz = 1'b0; upd_c = 1'b0; upd_v = 1'b0; bit_op = 1'b0;
    mem_in = 8'h00; load_p = 1'b0; flag_op = NOP; int_entry = 1'b0;
    brk_push = 1'b0;
  endtask

  // Drive one vector at the falling edge; the expected P is due after the next rising edge.
  task automatic vec(input logic [7:0] ar, input logic co, input logic vo,
                     input logic unz, input logic uc, input logic uv,
                     input logic bo, input logic [7:0] mi, input logic lp,
                     input logic [2:0] fo, input logic ie, input logic bp,
                     input logic [7:0] exp_p);
    @(negedge clk);
    alu_result = ar; alu_cout = co; alu_vout = vo;
    upd_nz = unz; upd_c = uc; upd_v = uv; bit_op = bo;
    mem_in = mi; load_p = lp; flag_op = fo; int_entry = ie; brk_push = bp;
    exp_q.push_back(exp_p);
  endtask

  initial begin
    int budget;
    idle_inputs();
    rst = 1'b1;
    brk_push = 1'b1;
    #3;
    check8("rst_p_brk1", p_out, 8'h34);
    brk_push = 1'b0;
    #1;
    check8("rst_p_brk0", p_out, 8'h24);
    @(negedge clk);
    rst = 1'b0;

    //   alu  co vo nz c  v  bit mem   lp op   ie bp  exp
    vec(8'h55, 0, 0, 0, 0, 0, 0, 8'h00, 0, CLI, 0, 0, 8'h20);
    vec(8'h00, 1, 1, 1, 1, 1, 0, 8'h00, 0, NOP, 0, 0, 8'h63);
    vec(8'h55, 0, 0, 0, 1, 0, 0, 8'hFF, 1, CLC, 0, 0, 8'hEF);
    vec(8'h01, 1, 1, 1, 1, 1, 1, 8'h30, 1, SEC, 1, 0, 8'h20);
    vec(8'h55, 0, 0, 0, 0, 0, 0, 8'h00, 0, SEC, 0, 0, 8'h21);
    vec(8'h00, 0, 0, 1, 0, 0, 1, 8'hC0, 0, NOP, 0, 0, 8'hE3);
    vec(8'h80, 0, 0, 1, 0, 0, 0, 8'h00, 0, SEC, 0, 0, 8'hE1);
    vec(8'h55, 0, 0, 0, 0, 0, 0, 8'h00, 0, CLI, 1, 0, 8'hE5);
    vec(8'h55, 0, 1, 0, 1, 1, 0, 8'h00, 0, CLV, 0, 0, 8'hA4);
    vec(8'h7F, 0, 0, 1, 0, 0, 0, 8'h00, 0, SED, 0, 0, 8'h2C);
    vec(8'h00, 0, 0, 1, 0, 0, 0, 8'h00, 0, NOP, 0, 1, 8'h3E);
    vec(8'h55, 0, 0, 0, 0, 0, 0, 8'h00, 0, CLD, 0, 0, 8'h26);
    vec(8'h55, 0, 0, 0, 0, 0, 0, 8'h00, 0, SEC, 0, 0, 8'h27);
    vec(8'h55, 0, 0, 0, 0, 0, 0, 8'h00, 0, CLC, 0, 0, 8'h26);
    for (int k = 0; k < 5; k++)
      vec(8'hAA, 1, 1, 0, 0, 0, 0, 8'hFF, 0, NOP, 0, 0, 8'h26);
    vec(8'h55, 0, 0, 0, 0, 0, 0, 8'h00, 0, CLI, 0, 0, 8'h22);

    // Reset between edges discards the pending update.
    @(negedge clk);
    idle_inputs();
    flag_op = SEC; upd_nz = 1'b1; alu_result = 8'h80; load_p = 1'b1; mem_in = 8'hCB;
    #2;
    rst = 1'b1;
    #1;
    check8("async_rst_p", p_out, 8'h24);
    check8("async_rst_ci", {6'd0, c_flag, i_flag}, 8'h01);
    @(posedge clk);
    #1;
    check8("rst_hold_p", p_out, 8'h24);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    vec(8'h55, 0, 0, 0, 0, 0, 0, 8'h00, 0, SEC, 0, 0, 8'h25);

    budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
